pc_sequencer: RTL

- Parametrised successor to the single-register program counter.
- Selects the next fetch address from several sources: sequential increment, branch, jump, jump-register, return-address-stack pop, and exception vector.
- Supports stall, detects misaligned targets, and keeps a small circular return-address stack (RAS).
- Sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-fetch-address selection with stall, misaligned-target
// trap, exception entry and a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned           ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]     RESET_VEC = 32'h00000000,
    parameter logic [ADDR_W-1:0]     EXC_VEC   = 32'h00000080,
    parameter int unsigned           INC       = 4,
    parameter int unsigned           RAS_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              JumpReg,
    input  logic [ADDR_W-1:0] RegTarget,
    input  logic              Call,
    input  logic              Ret,
    input  logic              Exception,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlusInc,
    output logic              Valid,
    output logic              Redirect,
    output logic              Misaligned,
    output logic [ADDR_W-1:0] EPC,
    output logic              RasEmpty,
    output logic              RasFull
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] ALIGN_M  = INC_V - ADDR_W'(1);
    localparam logic [CNT_W-1:0]  DEPTH_V  = CNT_W'(RAS_DEPTH);

    // Return-address stack storage and bookkeeping
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_wptr;
    logic [PTR_W-1:0]  ras_top_idx;
    logic [CNT_W-1:0]  ras_cnt;
    logic [ADDR_W-1:0] ras_top;

    // Next-state values produced by the selection logic
    logic [ADDR_W-1:0] nxt_pc;
    logic [ADDR_W-1:0] nxt_epc;
    logic              nxt_redirect;
    logic              nxt_mis;
    logic              do_push;
    logic              do_pop;

    // Intermediate selection signals
    logic [ADDR_W-1:0] tgt;
    logic              take;
    logic              push_req;
    logic              pop_req;
    logic              tgt_bad;

    assign PCPlusInc   = PC + INC_V;
    assign RasEmpty    = (ras_cnt == '0);
    assign RasFull     = (ras_cnt == DEPTH_V);
    assign ras_top_idx = ras_wptr - PTR_W'(1);
    assign ras_top     = ras_mem[ras_top_idx];
    assign tgt_bad     = ((tgt & ALIGN_M) != '0);

    // Pick the redirect source in priority order
    always_comb begin
        tgt      = '0;
        take     = 1'b0;
        push_req = 1'b0;
        pop_req  = 1'b0;
        if (Exception || Stall) begin
            take = 1'b0;
        end else if (BranchTaken) begin
            take = 1'b1;
            tgt  = BranchTarget;
        end else if (JumpReg && Ret && !RasEmpty) begin
            take     = 1'b1;
            tgt      = ras_top;
            pop_req  = 1'b1;
            push_req = Call;
        end else if (JumpReg) begin
            take     = 1'b1;
            tgt      = RegTarget;
            push_req = Call;
        end else if (Jump) begin
            take     = 1'b1;
            tgt      = JumpTarget;
            push_req = Call;
        end
    end

    // Resolve the final next PC, trap state and RAS action
    always_comb begin
        nxt_pc       = PC;
        nxt_epc      = EPC;
        nxt_redirect = 1'b0;
        nxt_mis      = 1'b0;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        if (!Valid) begin
            nxt_pc = PC;
        end else if (Exception) begin
            nxt_pc       = EXC_VEC;
            nxt_epc      = PC;
            nxt_redirect = 1'b1;
        end else if (Stall) begin
            nxt_pc = PC;
        end else if (take) begin
            nxt_redirect = 1'b1;
            if (tgt_bad) begin
                nxt_pc  = EXC_VEC;
                nxt_epc = tgt;
                nxt_mis = 1'b1;
            end else begin
                nxt_pc  = tgt;
                do_push = push_req;
                do_pop  = pop_req;
            end
        end else begin
            nxt_pc = PCPlusInc;
        end
    end

    // Architectural PC, EPC and status pulses
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            PC         <= RESET_VEC;
            EPC        <= '0;
            Valid      <= 1'b0;
            Redirect   <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            PC         <= nxt_pc;
            EPC        <= nxt_epc;
            Valid      <= 1'b1;
            Redirect   <= nxt_redirect;
            Misaligned <= nxt_mis;
        end
    end

    // RAS update; a combined pop+push replaces the top entry in place
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ras_wptr <= '0;
            ras_cnt  <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else if (do_pop && do_push) begin
            ras_mem[ras_top_idx] <= PCPlusInc;
        end else if (do_push) begin
            ras_mem[ras_wptr] <= PCPlusInc;
            ras_wptr          <= ras_wptr + PTR_W'(1);
            if (!RasFull) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (do_pop) begin
            ras_wptr <= ras_top_idx;
            ras_cnt  <= ras_cnt - CNT_W'(1);
        end
    end

endmodule
